interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// Four-source round-robin interrupt controller with a 4-byte memory-mapped
// register window (mask, raw requests, status) on a shared tristate bus.
module interrupt_controller #(
  parameter logic [7:0] BaseAddr = 8'hF0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [3:0] SRC_RAISE,
  output logic [3:0] SRC_ACK,
  output logic       CPU_INT_RAISE,
  input  logic       CPU_INT_ACK
);

  localparam int unsigned NumSrc = 4;
  localparam int unsigned IdW    = 2;
  localparam int unsigned DataW  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    ACK   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state, next_state;
  logic [NumSrc-1:0]  req, mask, eligible;
  logic [IdW-1:0]     active_id, active_id_d;
  logic [IdW-1:0]     last_id, last_id_d;
  logic               grant_valid;
  logic [IdW-1:0]     grant_id, cand;
  logic               raise_d;
  logic [NumSrc-1:0]  ack_d;

  logic [DataW-1:0]   offset;
  logic               in_window;
  logic [DataW-1:0]   rd_mux, rd_data;
  logic               rd_valid;
  logic               busy;

  // Only the low nibble of write data is meaningful.
  wire unused_bus_hi = ^BUS_DATA[7:4];

  assign eligible  = req & mask;
  assign busy      = (state != IDLE);
  assign offset    = BUS_ADDR - BaseAddr;
  assign in_window = (offset < DataW'(4));

  // Round-robin search starting one past the last acknowledged source.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NumSrc; i++) begin
      cand = IdW'(last_id + IdW'(i));
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and registered-output decode; outputs follow the next state.
  always_comb begin
    next_state  = state;
    active_id_d = active_id;
    last_id_d   = last_id;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          next_state  = RAISE;
          active_id_d = grant_id;
        end
      end
      RAISE: begin
        if (CPU_INT_ACK) begin
          next_state = ACK;
        end
      end
      ACK: begin
        next_state = HOLD;
        last_id_d  = active_id;
      end
      HOLD: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    raise_d = (next_state == RAISE);
    ack_d   = (next_state == ACK) ? (NumSrc'(1) << active_id_d) : '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      req           <= '0;
      mask          <= 4'hF;
      active_id     <= '0;
      last_id       <= IdW'(3);
      CPU_INT_RAISE <= 1'b0;
      SRC_ACK       <= '0;
    end else begin
      req           <= SRC_RAISE;
      active_id     <= active_id_d;
      last_id       <= last_id_d;
      CPU_INT_RAISE <= raise_d;
      SRC_ACK       <= ack_d;
      if (BUS_WE && in_window && (offset[1:0] == 2'd0)) begin
        mask <= BUS_DATA[3:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (offset[1:0])
      2'd0:    rd_mux = {4'b0, mask};
      2'd1:    rd_mux = {4'b0, req};
      2'd2:    rd_mux = {busy, 5'b0, active_id};
      default: rd_mux = '0;
    endcase
  end

  // Registered read: data captured at the address edge, driven the next cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= in_window && !BUS_WE;
      rd_data  <= rd_mux;
    end
  end

  assign BUS_DATA = (rd_valid && in_window && !BUS_WE) ? rd_data : {DataW{1'bz}};

endmodule
